// File: rtl/axil_reg_pkg.sv
// axil_reg_pkg: shared types, response codes and sizing helper for the AXI4-Lite register block
package axil_reg_pkg;
  typedef enum logic [1:0] {W_IDLE, W_COLLECT, W_RESP} wstate_t;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  function automatic int idx_width(input int n);
    return n < 2 ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/axil_reg_resp.sv
// axil_reg_resp: AXI4-Lite slave exposing N_REGS 32-bit byte-writable registers
module axil_reg_resp
  import axil_reg_pkg::*;
#(
  parameter int N_REGS = 8,
  parameter int AW = 40
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     s_axi_awvalid,
  input  logic [AW-1:0]            s_axi_awaddr,
  input  logic [2:0]               s_axi_awprot,
  output logic                     s_axi_awready,
  input  logic                     s_axi_wvalid,
  input  logic [31:0]              s_axi_wdata,
  input  logic [3:0]               s_axi_wstrb,
  output logic                     s_axi_wready,
  output logic                     s_axi_bvalid,
  output logic [1:0]               s_axi_bresp,
  input  logic                     s_axi_bready,
  input  logic                     s_axi_arvalid,
  input  logic [AW-1:0]            s_axi_araddr,
  input  logic [2:0]               s_axi_arprot,
  output logic                     s_axi_arready,
  output logic                     s_axi_rvalid,
  output logic [31:0]              s_axi_rdata,
  output logic [1:0]               s_axi_rresp,
  input  logic                     s_axi_rready,
  output logic [N_REGS*32-1:0]     regs_o,
  output logic [N_REGS-1:0]        wr_pulse_o
);
  localparam int IW = idx_width(N_REGS);
  wstate_t state;
  logic aw_held, w_held, w_ok, r_ok, unused;
  logic [AW-3:0] awaddr_q;
  logic [31:0] wdata_q, rd_val;
  logic [3:0] wstrb_q;
  logic [N_REGS-1:0][31:0] regs;
  // word address is in range only if the index fits and nothing above it is set
  function automatic logic in_rng(input logic [AW-3:0] w);
    return ((w >> IW) == '0) && (32'(w[IW-1:0]) < 32'(N_REGS));
  endfunction
  assign unused = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};
  assign regs_o = regs;
  assign s_axi_awready = state != W_RESP && !aw_held;
  assign s_axi_wready = state != W_RESP && !w_held;
  assign s_axi_arready = !s_axi_rvalid;
  assign w_ok = in_rng(awaddr_q);
  assign r_ok = in_rng(s_axi_araddr[AW-1:2]);
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < N_REGS; i++)
      if (s_axi_araddr[IW+1:2] == IW'(i)) rd_val = regs[i];
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= W_IDLE;
      aw_held <= 1'b0;
      w_held <= 1'b0;
      awaddr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      regs <= '0;
      wr_pulse_o <= '0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp <= RESP_OKAY;
    end else begin
      wr_pulse_o <= '0;
      case (state)
        W_IDLE, W_COLLECT: begin
          if (aw_held && w_held) begin
            for (int i = 0; i < N_REGS; i++)
              if (w_ok && awaddr_q[IW-1:0] == IW'(i)) begin
                for (int b = 0; b < 4; b++)
                  if (wstrb_q[b]) regs[i][8*b+:8] <= wdata_q[8*b+:8];
                wr_pulse_o[i] <= 1'b1;
              end
            s_axi_bvalid <= 1'b1;
            s_axi_bresp <= w_ok ? RESP_OKAY : RESP_DECERR;
            state <= W_RESP;
          end else begin
            if (s_axi_awvalid && s_axi_awready) begin
              aw_held <= 1'b1;
              awaddr_q <= s_axi_awaddr[AW-1:2];
            end
            if (s_axi_wvalid && s_axi_wready) begin
              w_held <= 1'b1;
              wdata_q <= s_axi_wdata;
              wstrb_q <= s_axi_wstrb;
            end
            state <= (aw_held || w_held || s_axi_awvalid || s_axi_wvalid) ? W_COLLECT : W_IDLE;
          end
        end
        W_RESP: if (s_axi_bready) begin
          s_axi_bvalid <= 1'b0;
          aw_held <= 1'b0;
          w_held <= 1'b0;
          state <= W_IDLE;
        end
        default: state <= W_IDLE;
      endcase
    end
  end
  // the read samples regs before any same-edge commit lands, giving the pre-write value
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s_axi_rvalid <= 1'b0;
      s_axi_rdata <= '0;
      s_axi_rresp <= RESP_OKAY;
    end else if (s_axi_arvalid && s_axi_arready) begin
      s_axi_rvalid <= 1'b1;
      s_axi_rdata <= r_ok ? rd_val : '0;
      s_axi_rresp <= r_ok ? RESP_OKAY : RESP_DECERR;
    end else if (s_axi_rready) s_axi_rvalid <= 1'b0;
  end
endmodule

// File: tb/tb_axil_reg_resp.sv
// tb_axil_reg_resp: directed self-checking bench for axil_reg_resp
module tb_axil_reg_resp;
  logic aclk = 1'b0, aresetn = 1'b0;
  logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic [39:0] awaddr = '0, araddr = '0;
  logic [31:0] wdata = '0;
  logic [3:0] wstrb = '0;
  logic awready, wready, bvalid, arready, rvalid;
  logic [1:0] bresp, rresp;
  logic [31:0] rdata;
  logic [255:0] regs_o, snap;
  logic [7:0] wr_pulse_o, pulse;
  logic [1:0] resp;
  logic [31:0] rd;
  logic ok;
  int tests = 0, fails = 0;
  always #5 aclk = ~aclk;
  axil_reg_resp dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_awvalid(awvalid), .s_axi_awaddr(awaddr), .s_axi_awprot(3'b000), .s_axi_awready(awready),
    .s_axi_wvalid(wvalid), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wready(wready),
    .s_axi_bvalid(bvalid), .s_axi_bresp(bresp), .s_axi_bready(bready),
    .s_axi_arvalid(arvalid), .s_axi_araddr(araddr), .s_axi_arprot(3'b000), .s_axi_arready(arready),
    .s_axi_rvalid(rvalid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rready(rready),
    .regs_o(regs_o), .wr_pulse_o(wr_pulse_o)
  );
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [39:0] a, input logic [31:0] d, input logic [3:0] s,
                    output logic [1:0] r, output logic [7:0] p, output logic got);
    awvalid = 1; awaddr = a; wvalid = 1; wdata = d; wstrb = s; bready = 1;
    @(negedge aclk);
    awvalid = 0; wvalid = 0; got = 0; r = 'x; p = 'x;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge aclk);
      if (bvalid) begin got = 1; r = bresp; p = wr_pulse_o; end
    end
    @(negedge aclk);
  endtask
  task automatic rdt(input logic [39:0] a, output logic [31:0] d, output logic [1:0] r, output logic got);
    arvalid = 1; araddr = a; rready = 1; got = 0; d = 'x; r = 'x;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge aclk);
      arvalid = 0;
      if (rvalid) begin got = 1; d = rdata; r = rresp; end
    end
    @(negedge aclk);
    rready = 0;
  endtask
  initial begin
    #12;
    chk("rst_awready", awready, 1); chk("rst_wready", wready, 1); chk("rst_arready", arready, 1);
    chk("rst_bvalid", bvalid, 0); chk("rst_rvalid", rvalid, 0); chk("rst_rdata", rdata, 0);
    chk("rst_regs", regs_o, 0); chk("rst_pulse", wr_pulse_o, 0);
    @(negedge aclk);
    aresetn = 1;
    awvalid = 1; awaddr = 40'h4; wvalid = 1; wdata = 32'hDEADBEEF; wstrb = 4'hF; bready = 1;
    @(negedge aclk);
    awvalid = 0; wvalid = 0;
    chk("w1_not_yet", bvalid, 0);
    chk("w1_reg_old", regs_o[63:32], 0);
    @(negedge aclk);
    chk("w1_reg1", regs_o[63:32], 32'hDEADBEEF);
    chk("w1_pulse", wr_pulse_o, 8'h02);
    chk("w1_bvalid", bvalid, 1);
    chk("w1_bresp", bresp, 2'b00);
    @(negedge aclk);
    chk("w1_pulse_gone", wr_pulse_o, 0);
    chk("w1_bvalid_gone", bvalid, 0);
    wr(40'h8, 32'hFFFFFFFF, 4'hF, resp, pulse, ok);
    chk("w2_done", ok, 1);
    chk("w2_reg2", regs_o[95:64], 32'hFFFFFFFF);
    wvalid = 1; wdata = 32'h11223344; wstrb = 4'b0101;
    @(negedge aclk);
    wvalid = 0;
    chk("wfirst_wready", wready, 0);
    chk("wfirst_awready", awready, 1);
    @(negedge aclk); @(negedge aclk);
    chk("wfirst_nob", bvalid, 0);
    awvalid = 1; awaddr = 40'h8;
    @(negedge aclk);
    awvalid = 0;
    @(negedge aclk);
    chk("wfirst_bvalid", bvalid, 1);
    chk("wfirst_reg2", regs_o[95:64], 32'hFF22FF44);
    chk("wfirst_pulse", wr_pulse_o, 8'h04);
    @(negedge aclk);
    arvalid = 1; araddr = 40'h4; rready = 0;
    @(negedge aclk);
    arvalid = 0;
    for (int i = 0; i < 5; i++) begin
      chk("rhold_rvalid", rvalid, 1);
      chk("rhold_rdata", rdata, 32'hDEADBEEF);
      chk("rhold_arready", arready, 0);
      @(negedge aclk);
    end
    rready = 1;
    @(negedge aclk);
    chk("rhold_release", rvalid, 0);
    chk("rhold_arready_back", arready, 1);
    rready = 0;
    snap = regs_o;
    wr(40'h40, 32'hCAFEF00D, 4'hF, resp, pulse, ok);
    chk("oor_done", ok, 1);
    chk("oor_bresp", resp, 2'b11);
    chk("oor_pulse", pulse, 0);
    chk("oor_regs", regs_o, snap);
    rdt(40'h40, rd, resp, ok);
    chk("oor_rdone", ok, 1);
    chk("oor_rresp", resp, 2'b11);
    chk("oor_rdata", rd, 0);
    rdt(40'h1_0000_0004, rd, resp, ok);
    chk("oor_high_rresp", resp, 2'b11);
    awvalid = 1; awaddr = 40'hC; wvalid = 1; wdata = 32'h5A5A5A5A; wstrb = 4'hF; bready = 1;
    @(negedge aclk);
    awvalid = 0; wvalid = 0;
    arvalid = 1; araddr = 40'hC; rready = 1;
    @(negedge aclk);
    arvalid = 0;
    chk("same_rvalid", rvalid, 1);
    chk("same_rdata_old", rdata, 0);
    chk("same_reg3", regs_o[127:96], 32'h5A5A5A5A);
    @(negedge aclk);
    rready = 0;
    rdt(40'hC, rd, resp, ok);
    chk("same_reread", rd, 32'h5A5A5A5A);
    chk("same_rresp", resp, 2'b00);
    bready = 0;
    awvalid = 1; awaddr = 40'h14; wvalid = 1; wdata = 32'h01020304; wstrb = 4'hF;
    @(negedge aclk);
    awvalid = 0; wvalid = 0;
    @(negedge aclk); @(negedge aclk); @(negedge aclk);
    chk("bhold_bvalid", bvalid, 1);
    chk("bhold_awready", awready, 0);
    #2 aresetn = 0;
    #1;
    chk("arst_bvalid", bvalid, 0);
    chk("arst_regs", regs_o, 0);
    chk("arst_awready", awready, 1);
    @(negedge aclk);
    aresetn = 1;
    awvalid = 1; awaddr = 40'h10;
    @(negedge aclk);
    awvalid = 0;
    #2 aresetn = 0;
    @(negedge aclk);
    aresetn = 1;
    wvalid = 1; wdata = 32'h77777777; wstrb = 4'hF; bready = 1;
    @(negedge aclk);
    wvalid = 0;
    @(negedge aclk); @(negedge aclk);
    chk("abandon_nob", bvalid, 0);
    chk("abandon_regs", regs_o, 0);
    awvalid = 1; awaddr = 40'h1C;
    @(negedge aclk);
    awvalid = 0;
    @(negedge aclk);
    chk("abandon_finish", regs_o[255:224], 32'h77777777);
    @(negedge aclk);
    wr(40'h14, 32'hABCD1234, 4'b1100, resp, pulse, ok);
    chk("post_done", ok, 1);
    chk("post_bresp", resp, 2'b00);
    chk("post_pulse", pulse, 8'h20);
    chk("post_reg5", regs_o[191:160], 32'hABCD0000);
    rdt(40'h14, rd, resp, ok);
    chk("post_read", rd, 32'hABCD0000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/axil_reg_resp.md
AXIL_REG_RESP -- requirements
Module: axil_reg_resp

Interface
REQ-001 SHALL have parameter N_REGS, default 8, meaning the number of 32-bit registers (2..64).
REQ-002 SHALL have parameter AW, default 40, meaning the address width, matching the CPU master port.
REQ-003 SHALL have port aclk, input, 1, the single clock; all logic is on the rising edge.
REQ-004 SHALL have port aresetn, input, 1, the asynchronous active-low reset.
REQ-005 SHALL have AXI4-Lite slave inputs: s_axi_awvalid 1, s_axi_awaddr AW, s_axi_awprot 3, s_axi_wvalid 1, s_axi_wdata 32, s_axi_wstrb 4, s_axi_bready 1, s_axi_arvalid 1, s_axi_araddr AW, s_axi_arprot 3, s_axi_rready 1.
REQ-006 SHALL have AXI4-Lite slave outputs: s_axi_awready 1, s_axi_wready 1, s_axi_bvalid 1, s_axi_bresp 2, s_axi_arready 1, s_axi_rvalid 1, s_axi_rdata 32, s_axi_rresp 2.
REQ-007 SHALL have output regs_o, N_REGS*32 bits: the current register contents, with register i at bits [32i+31:32i].
REQ-008 SHALL have output wr_pulse_o, N_REGS bits: a one-cycle pulse on the cycle a register is written.

Function
REQ-009 SHALL decode the register index from addr[log2(N_REGS)+1:2]. Addr[1:0] is ignored. An address with index >= N_REGS, or any set bit above the index field, is out of range.
REQ-010 SHALL ignore awprot and arprot.
REQ-011 Write channel SHALL be a 3-state FSM: W_IDLE, W_COLLECT, W_RESP.
REQ-012 W_IDLE and W_COLLECT:
- s_axi_awready = !aw_held; s_axi_wready = !w_held.
- AW and W SHALL be accepted independently, in either order or in the same cycle.
- Accepted address and data/strobe are latched.
REQ-013 When both AW and W are held (including a same-cycle handshake), the next edge SHALL:
- commit the write: each byte lane with wstrb set is updated; lanes with wstrb clear are unchanged;
- pulse wr_pulse_o[idx] for exactly that cycle;
- set s_axi_bvalid=1 and move to W_RESP.
Latency: AW and W handshake on edge k gives the register update and bvalid on edge k+1.
REQ-014 An out-of-range write SHALL update no register, pulse no wr_pulse_o bit, and return bresp=2'b11 (DECERR). An in-range write returns bresp=2'b00.
REQ-015 In W_RESP, awready and wready SHALL be 0. bvalid and bresp SHALL hold until s_axi_bready=1. On that edge bvalid deasserts, the held flags clear, and the FSM returns to W_IDLE.
REQ-016 Read channel: s_axi_arready = !s_axi_rvalid.
- An AR handshake on edge k SHALL present rvalid=1, rdata and rresp after edge k.
- rdata, rresp and rvalid SHALL hold until s_axi_rready=1.
- Back-to-back reads SHALL sustain one read per two cycles.
REQ-017 An out-of-range read SHALL return rdata=0 and rresp=2'b11. An in-range read returns the register value and rresp=2'b00.
REQ-018 A read and a write commit to the same register on the same edge: the read SHALL return the pre-write value.
REQ-019 Read and write channels SHALL operate concurrently and independently.
REQ-020 bvalid and rvalid SHALL never deassert without the matching ready.

Reset
REQ-021 While aresetn=0, asynchronously:
- all registers = 0; regs_o = 0; wr_pulse_o = 0;
- bvalid = 0, rvalid = 0, bresp = 0, rresp = 0, rdata = 0;
- write FSM in W_IDLE with held flags clear;
- awready, wready, arready evaluate to 1.
REQ-022 Reset asserted mid-transaction SHALL abandon it: no register update and no response after release.
REQ-023 The first handshake SHALL be accepted on the first rising edge with aresetn=1.

Structure
REQ-024 The package axil_reg_pkg SHALL hold:
- the write-FSM state enum;
- the response constants RESP_OKAY = 2'b00 and RESP_DECERR = 2'b11;
- a function computing the index width from N_REGS.
REQ-025 Implementation SHALL be a single module, with no sub-module; the register array is inferred flops.

Verification
REQ-026 Same-cycle AW+W, addr 0x4, data 0xDEADBEEF, wstrb 4'hF, bready=1: reg1=0xDEADBEEF, wr_pulse_o=8'h02 for one cycle, bresp=00.
REQ-027 W before AW: W to 0x8 with data 0x11223344 and wstrb 4'b0101, then AW 3 cycles later, with reg2 initially 0xFFFFFFFF: reg2=0xFF22FF44.
REQ-028 Read 0x4 after REQ-026 with rready held 0 for 5 cycles: rvalid stays 1, rdata=0xDEADBEEF stable, arready=0 throughout.
REQ-029 Write and read to 0x40 (out of range, N_REGS=8): bresp=11, rresp=11, rdata=0, regs_o unchanged, no wr_pulse_o.
REQ-030 Same-edge commit to reg3 (0x0 to 0x5A5A5A5A) and AR to 0xC: rdata=0x00000000; a following read returns 0x5A5A5A5A.
REQ-031 aresetn pulsed low while bvalid=1 and bready=0: bvalid=0 immediately, regs_o=0, and a new write completes normally.
